branch_resolve_queue: RTL and testbench
=======================================

Name: branch_resolve_queue

Overview:
In-order queue between fetch-stage direction prediction and execute-stage branch resolution. Holds each predicted branch's PC, predicted direction and predicted target until execute resolves it. Compares the prediction with the actual outcome and drives the GShare predictor's update port (updatePc/update/reality). Raises a registered redirect/flush toward fetch on a mispredict.

Parameters:
BIT_WIDTH, 32, PC and target width
DEPTH, 8, queue entries; power of two, at least 2
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
enq_valid  in  1  fetch pushes a predicted branch
enq_ready  out  1  queue not full; combinational, equals !full
enq_pc  in  BIT_WIDTH  branch PC
enq_pred  in  1  predicted direction (predictor prediction bit)
enq_target  in  BIT_WIDTH  predicted target; used only when enq_pred=1
res_valid  in  1  execute resolves the oldest outstanding branch
res_taken  in  1  actual direction
res_target  in  BIT_WIDTH  actual taken target
upd_valid  out  1  predictor update strobe (to update)
upd_pc  out  BIT_WIDTH  to updatePc
upd_taken  out  1  to reality
redirect  out  1  one-cycle mispredict pulse; flushes fetch
redirect_pc  out  BIT_WIDTH  correct next PC
count  out  PTR_W+1  occupied entries
err_underflow  out  1  sticky: resolve arrived while the queue was empty

Behaviour:
- Reset (asynchronous, rst_n=0): head=tail=0, count=0, and upd_valid, redirect and err_underflow all 0. upd_pc, upd_taken and redirect_pc reset to 0. Entry storage is not reset.
- Enqueue: enq_valid && enq_ready at a clk edge writes {pc, pred, target} at tail, and tail increments modulo DEPTH. No bypass: when full, enq_ready=0 even if res_valid=1 in the same cycle.
- Resolve: res_valid with count>0 pops the head entry. Both outcomes are registered, so there is 1-cycle latency:
  - Update: upd_valid=1, upd_pc=entry.pc, upd_taken=res_taken.
  - Mispredict when (entry.pred != res_taken) || (res_taken && entry.target != res_target). Then redirect=1 and redirect_pc = res_taken ? res_target : entry.pc+4, with modulo 2^BIT_WIDTH wrap.
- Flush on mispredict: in the same edge that pops the mispredicted entry, all younger entries are discarded (head=tail, count=0). An enqueue in that same cycle is dropped, because the entry is wrong-path.
- Simultaneous enqueue and resolve with no mispredict: both occur, and count is unchanged.
- Resolve with count=0: no pop and no upd_valid. err_underflow is set and holds until reset.
- Both upd_valid and redirect are single-cycle pulses, deasserted in every cycle without a pop.
- Wrap-around: pointers are PTR_W bits wide and wrap naturally. full = (count==DEPTH), empty = (count==0).
- Reset mid-operation: all state clears immediately. Pulses in flight are lost, and outputs go to reset values asynchronously.
- No state machine beyond the queue. count is the only occupancy state.

Optional Feature:
Macro BRQ_STATS_EN.
- Defined: adds outputs stat_resolved[31:0] and stat_mispred[31:0]. They increment on each pop and on each mispredict pop, saturate at 0xFFFFFFFF, and reset to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package bp_pkg holds:
  - the entry struct brq_entry_t {pc, pred, target}
  - the constant INSN_BYTES=4, used for the fall-through PC
  - the BIT_WIDTH default, shared with the predictor
- One sub-module, brq_fifo_mem: DEPTH x entry register array, with 1 write port and a combinational read at head.
- Mispredict compare and output registers live in the top module.

Test Plan:
- Push pc=0x100 pred=1 tgt=0x200, then resolve taken tgt=0x200 -> next cycle upd_valid=1, upd_pc=0x100, upd_taken=1, redirect=0, count=0.
- Push pc=0x104 pred=1 tgt=0x300, then resolve not-taken -> redirect=1, redirect_pc=0x108, upd_taken=0.
- Push 3 entries, then resolve the first as taken with tgt=0x500 against predicted 0x400 -> redirect_pc=0x500 and count=0. A simultaneous enqueue is dropped.
- Push 8 entries -> enq_ready=0 and count=8. A 9th push plus a correct resolve in the same cycle -> count=7, and the 9th entry is not stored. Then push 20 more, interleaved with resolves, to exercise pointer wrap; popped PCs match push order.
- Resolve with the queue empty -> err_underflow=1 and stays 1, with no upd_valid. Assert rst_n=0 mid-stream -> count=0, err_underflow=0 and redirect=0 immediately.
- With BRQ_STATS_EN: 5 resolves, 2 of them mispredicted -> stat_resolved=5, stat_mispred=2.

Source files
------------

// File: rtl/bp_pkg.sv
// Types and constants shared between the GShare predictor and the branch resolve queue.
package bp_pkg;

  localparam int BP_BIT_WIDTH = 32;
  localparam int INSN_BYTES   = 4;

  typedef struct packed {
    logic [BP_BIT_WIDTH-1:0] pc;
    logic                    pred;
    logic [BP_BIT_WIDTH-1:0] target;
  } brq_entry_t;

endpackage

// File: rtl/brq_fifo_mem.sv
// Entry storage for the branch resolve queue: one write port, combinational read at head.
module brq_fifo_mem
  import bp_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter int  PTR_W   = $clog2(DEPTH),
  parameter type entry_t = brq_entry_t
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  entry_t           wdata,
  input  logic [PTR_W-1:0] raddr,
  output entry_t           rdata
);

  entry_t mem_q [DEPTH];

  // Storage is deliberately not reset; occupancy is tracked by the queue pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; resolves them against execute, updates the predictor
// and redirects fetch on mispredict. Optional counters enabled with macro BRQ_STATS_EN.
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int  BIT_WIDTH = BP_BIT_WIDTH,
  parameter int  DEPTH     = 8,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enq_valid,
  output logic                 enq_ready,
  input  logic [BIT_WIDTH-1:0] enq_pc,
  input  logic                 enq_pred,
  input  logic [BIT_WIDTH-1:0] enq_target,
  input  logic                 res_valid,
  input  logic                 res_taken,
  input  logic [BIT_WIDTH-1:0] res_target,
  output logic                 upd_valid,
  output logic [BIT_WIDTH-1:0] upd_pc,
  output logic                 upd_taken,
  output logic                 redirect,
  output logic [BIT_WIDTH-1:0] redirect_pc,
  output logic [PTR_W:0]       count,
  output logic                 err_underflow
`ifdef BRQ_STATS_EN
  ,
  output logic [31:0]          stat_resolved,
  output logic [31:0]          stat_mispred
`endif
);

  typedef struct packed {
    logic [BIT_WIDTH-1:0] pc;
    logic                 pred;
    logic [BIT_WIDTH-1:0] target;
  } entry_t;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]       count_q, count_d;
  logic                 upd_valid_q, upd_valid_d;
  logic [BIT_WIDTH-1:0] upd_pc_q, upd_pc_d;
  logic                 upd_taken_q, upd_taken_d;
  logic                 redirect_q, redirect_d;
  logic [BIT_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                 err_q, err_d;

  logic   full_s, empty_s, push_s, pop_s, mispred_s;
  entry_t wr_entry_s, head_entry_s;

  brq_fifo_mem #(
    .DEPTH   (DEPTH),
    .PTR_W   (PTR_W),
    .entry_t (entry_t)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (tail_q),
    .wdata (wr_entry_s),
    .raddr (head_q),
    .rdata (head_entry_s)
  );

  // Handshake and mispredict detection; a wrong-path enqueue is dropped on flush.
  always_comb begin
    full_s     = (count_q == DEPTH_C);
    empty_s    = (count_q == {(PTR_W+1){1'b0}});
    pop_s      = res_valid & ~empty_s;
    mispred_s  = pop_s & ((head_entry_s.pred != res_taken) |
                          (res_taken & (head_entry_s.target != res_target)));
    push_s     = enq_valid & ~full_s & ~mispred_s;
    wr_entry_s = '{pc: enq_pc, pred: enq_pred, target: enq_target};
  end

  // Next pointers and occupancy.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (mispred_s) begin
      head_d  = tail_q;
      count_d = {(PTR_W+1){1'b0}};
    end else begin
      if (pop_s) begin
        head_d = head_q + PTR_W'(1'b1);
      end else begin
        head_d = head_q;
      end
      if (push_s) begin
        tail_d = tail_q + PTR_W'(1'b1);
      end else begin
        tail_d = tail_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + (PTR_W+1)'(1'b1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Next predictor-update and redirect outputs; data holds between pulses.
  always_comb begin
    upd_valid_d   = pop_s;
    upd_pc_d      = upd_pc_q;
    upd_taken_d   = upd_taken_q;
    redirect_d    = mispred_s;
    redirect_pc_d = redirect_pc_q;
    err_d         = err_q | (res_valid & empty_s);
    if (pop_s) begin
      upd_pc_d    = head_entry_s.pc;
      upd_taken_d = res_taken;
    end else begin
      upd_pc_d    = upd_pc_q;
      upd_taken_d = upd_taken_q;
    end
    if (mispred_s) begin
      redirect_pc_d = res_taken ? res_target
                                : head_entry_s.pc + BIT_WIDTH'(INSN_BYTES);
    end else begin
      redirect_pc_d = redirect_pc_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q        <= {PTR_W{1'b0}};
      tail_q        <= {PTR_W{1'b0}};
      count_q       <= {(PTR_W+1){1'b0}};
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= {BIT_WIDTH{1'b0}};
      upd_taken_q   <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= {BIT_WIDTH{1'b0}};
      err_q         <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      upd_valid_q   <= upd_valid_d;
      upd_pc_q      <= upd_pc_d;
      upd_taken_q   <= upd_taken_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      err_q         <= err_d;
    end
  end

  assign enq_ready     = ~full_s;
  assign count         = count_q;
  assign upd_valid     = upd_valid_q;
  assign upd_pc        = upd_pc_q;
  assign upd_taken     = upd_taken_q;
  assign redirect      = redirect_q;
  assign redirect_pc   = redirect_pc_q;
  assign err_underflow = err_q;

`ifdef BRQ_STATS_EN
  logic [31:0] stat_resolved_q, stat_resolved_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  // Saturating pop / mispredict counters.
  always_comb begin
    stat_resolved_d = stat_resolved_q;
    stat_mispred_d  = stat_mispred_q;
    if (pop_s && (stat_resolved_q != 32'hFFFF_FFFF)) begin
      stat_resolved_d = stat_resolved_q + 32'd1;
    end else begin
      stat_resolved_d = stat_resolved_q;
    end
    if (mispred_s && (stat_mispred_q != 32'hFFFF_FFFF)) begin
      stat_mispred_d = stat_mispred_q + 32'd1;
    end else begin
      stat_mispred_d = stat_mispred_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_resolved_q <= 32'd0;
      stat_mispred_q  <= 32'd0;
    end else begin
      stat_resolved_q <= stat_resolved_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_resolved = stat_resolved_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized + directed scoreboard bench for branch_resolve_queue against a queue-based model.
module tb_branch_resolve_queue;

  localparam int DEPTH = 8;

  logic        clk, rst_n;
  logic        enq_valid, enq_ready, enq_pred;
  logic [31:0] enq_pc, enq_target;
  logic        res_valid, res_taken;
  logic [31:0] res_target;
  logic        upd_valid, upd_taken, redirect, err_underflow;
  logic [31:0] upd_pc, redirect_pc;
  logic [3:0]  count;
`ifdef BRQ_STATS_EN
  logic [31:0] stat_resolved, stat_mispred;
`endif

  branch_resolve_queue #(.BIT_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
    .enq_pred(enq_pred), .enq_target(enq_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .count(count), .err_underflow(err_underflow)
`ifdef BRQ_STATS_EN
    , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic        taken;
    logic        redir;
    logic [31:0] rpc;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  logic m_err = 1'b0;
  int   exp_resolved = 0, exp_mis = 0;
  int   n_vec = 0, n_bad = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares every predictor-update / redirect pulse against the scoreboard.
  always @(negedge clk) begin
    exp_t x;
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        x = exp_q.pop_front();
        chk("upd_valid", 32'(upd_valid), 32'd1);
        chk("upd_pc", upd_pc, x.pc);
        chk("upd_taken", 32'(upd_taken), 32'(x.taken));
        chk("redirect", 32'(redirect), 32'(x.redir));
        if (x.redir) chk("redirect_pc", redirect_pc, x.rpc);
      end else begin
        chk("upd_valid_idle", 32'(upd_valid), 32'd0);
        chk("redirect_idle", 32'(redirect), 32'd0);
      end
    end
  end

  // One clock of stimulus; the model decides from pre-edge state.
  task automatic step(input logic ev, input logic [31:0] epc, input logic ep, input logic [31:0] et,
                      input logic rv, input logic rt, input logic [31:0] rtg);
    bit acc, pop, mis;
    ent_t h, n;
    exp_t x;
    enq_valid = ev; enq_pc = epc; enq_pred = ep; enq_target = et;
    res_valid = rv; res_taken = rt; res_target = rtg;
    acc = ev && (mq.size() < DEPTH);
    pop = rv && (mq.size() > 0);
    mis = 1'b0;
    if (pop) begin
      h   = mq[0];
      mis = (h.pred != rt) || (rt && (h.tgt != rtg));
      x.cyc = cyc + 1; x.pc = h.pc; x.taken = rt; x.redir = mis;
      x.rpc = rt ? rtg : h.pc + 32'd4;
      exp_q.push_back(x);
      exp_resolved++;
      if (mis) exp_mis++;
    end
    if (rv && mq.size() == 0) m_err = 1'b1;
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (mis) mq.delete();
    else if (acc) begin
      n.pc = epc; n.pred = ep; n.tgt = et;
      mq.push_back(n);
    end
    @(negedge clk); #1;
    chk("count", 32'(count), 32'(mq.size()));
    chk("enq_ready", 32'(enq_ready), 32'(mq.size() < DEPTH));
    chk("err_underflow", 32'(err_underflow), 32'(m_err));
    enq_valid = 1'b0; res_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
    step(1'b1, pc, pred, tgt, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic resolve_ok(input logic ev, input logic [31:0] epc);
    ent_t h;
    h = mq[0];
    step(ev, epc, epc[2], epc + 32'h40, 1'b1, h.pred, h.pred ? h.tgt : $urandom);
  endtask

  initial begin
    logic ev, ep, rv, rt;
    logic [31:0] epc, et, rtg;
    int k;
    rst_n = 1'b0; enq_valid = 1'b0; enq_pc = 32'd0; enq_pred = 1'b0; enq_target = 32'd0;
    res_valid = 1'b0; res_taken = 1'b0; res_target = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_enq_ready", 32'(enq_ready), 32'd1);
    chk("rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("rst_upd_pc", upd_pc, 32'd0);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_err", 32'(err_underflow), 32'd0);
    rst_n = 1'b1;

    // Correct taken prediction, then direction mispredict (fall-through redirect).
    push(32'h100, 1'b1, 32'h200);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h200);
    push(32'h104, 1'b1, 32'h300);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h0);

    // Target mispredict flushes younger entries and drops the same-cycle enqueue.
    push(32'h10, 1'b1, 32'h400);
    push(32'h14, 1'b1, 32'h400);
    push(32'h18, 1'b1, 32'h400);
    step(1'b1, 32'h99, 1'b1, 32'h123, 1'b1, 1'b1, 32'h500);
    push(32'h20, 1'b0, 32'h0);
    resolve_ok(1'b0, 32'd0);

    // Fill, push while full with a resolve, then wrap the pointers.
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(4 * i), 1'(i), 32'h2000 + 32'(16 * i));
    resolve_ok(1'b1, 32'hDEAD0);
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 2) push(32'h3000 + 32'(4 * i), 1'(i >> 1), 32'h5000 + 32'(i));
      else resolve_ok(1'b1, 32'h3000 + 32'(4 * i));
    end
    while (mq.size() > 0) resolve_ok(1'b0, 32'd0);

    // Underflow is sticky and produces no update.
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'h0);

    // Reset while a redirect pulse is on the outputs.
    push(32'h700, 1'b0, 32'h0);
    push(32'h704, 1'b1, 32'h900);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h800);
    rst_n = 1'b0;
    #1;
    chk("midrst_redirect", 32'(redirect), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_err", 32'(err_underflow), 32'd0);
    chk("midrst_upd_valid", 32'(upd_valid), 32'd0);
    mq.delete(); exp_q.delete(); m_err = 1'b0; exp_resolved = 0; exp_mis = 0;
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      ev  = ($urandom_range(0, 99) < 60);
      epc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      ep  = 1'($urandom_range(0, 1));
      et  = $urandom;
      if (mq.size() > 0) begin
        rv  = ($urandom_range(0, 99) < 50);
        k   = $urandom_range(0, 9);
        rt  = mq[0].pred;
        rtg = mq[0].pred ? mq[0].tgt : $urandom;
        if (k == 0) rt = ~mq[0].pred;
        if (k == 1) begin rt = 1'b1; rtg = mq[0].tgt ^ 32'h10; end
        if (k == 2) begin rt = 1'b0; rtg = $urandom; end
      end else begin
        rv = ($urandom_range(0, 99) < 3); rt = 1'b1; rtg = $urandom;
      end
      step(ev, epc, ep, et, rv, rt, rtg);
    end

    repeat (3) step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef BRQ_STATS_EN
    chk("stat_resolved", stat_resolved, 32'(exp_resolved));
    chk("stat_mispred", stat_mispred, 32'(exp_mis));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
